// File: rtl/sd_block_server_pkg.sv
// Shared types and constants for the SD block-device server.
package sd_srv_pkg;
   typedef enum logic [2:0] {IDLE, ACK, XFER, DRAIN, DONE} state_e;

   localparam int SECTOR_BYTES = 512;
   localparam int SLOT_FD1     = 0;
   localparam int SLOT_HDD     = 1;
   localparam int SLOT_FD2     = 2;
   localparam int SLOT_W       = 2;
   localparam int DEF_NUM_DEV  = 3;
   localparam int DEF_SECT_W   = 15;
endpackage

// File: rtl/sd_block_server_if.sv
// Request/ack, sector-buffer and image-memory signals of the SD block server.
interface sd_block_server_if #(
   parameter int NUM_DEV = sd_srv_pkg::DEF_NUM_DEV,
   parameter int SECT_W  = sd_srv_pkg::DEF_SECT_W,
   parameter int IMG_AW  = sd_srv_pkg::SLOT_W + SECT_W + 9
);
   logic [NUM_DEV*32-1:0] sd_lba;
   logic [NUM_DEV-1:0]    sd_rd;
   logic [NUM_DEV-1:0]    sd_wr;
   logic [NUM_DEV-1:0]    dev_mounted;
   logic [NUM_DEV-1:0]    sd_ack;
   logic [8:0]            sd_buff_addr;
   logic [7:0]            sd_buff_dout;
   logic                  sd_buff_wr;
   logic [NUM_DEV*8-1:0]  sd_buff_din;
   logic [IMG_AW-1:0]     img_addr;
   logic                  img_rd;
   logic [7:0]            img_dout;
   logic                  img_wr;
   logic [7:0]            img_din;
   logic                  err;

   modport master (
      output sd_lba, sd_rd, sd_wr, dev_mounted, sd_buff_din, img_dout,
      input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
             img_addr, img_rd, img_wr, img_din, err
   );

   modport slave (
      input  sd_lba, sd_rd, sd_wr, dev_mounted, sd_buff_din, img_dout,
      output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
             img_addr, img_rd, img_wr, img_din, err
   );
endinterface

// File: rtl/sd_block_server_rr_arbiter.sv
// Combinational round-robin arbiter: first pending request at or after ptr_i.
module rr_arbiter #(
   parameter  int N  = 3,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   input  logic          en_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o
);
   int   j;
   logic found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = 0;
      for (int i = 0; i < N; i++) begin
         j = int'(ptr_i) + i;
         if (j >= N) j = j - N;
         if (en_i && !found && req_i[j]) begin
            found    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = IW'(j);
         end
      end
   end
endmodule

// File: rtl/sd_block_server.sv
// Arbitrates per-drive sector requests and moves one 512-byte sector between
// the flat image memory and the requester's buffer with the ack rise/hold/fall handshake.
//
// state | meaning
// IDLE  | waiting for a request, round-robin grant
// ACK   | ack raised, requester drops its request
// XFER  | 512 byte beats issued (counter 0..511)
// DRAIN | completes beat 511
// DONE  | ack dropped, transfer complete
module sd_block_server
   import sd_srv_pkg::*;
#(
   parameter int NUM_DEV = DEF_NUM_DEV,
   parameter int SECT_W  = DEF_SECT_W,
   parameter int IMG_AW  = SLOT_W + SECT_W + 9
) (
   input  logic               clk_sys,
   input  logic               reset_n,
   sd_block_server_if.slave   bus
);
   state_e              state_q, state_d;
   logic [SLOT_W-1:0]   slot_q, slot_d, ptr_q, ptr_d;
   logic [SECT_W-1:0]   lba_q, lba_d;
   logic                wr_q, wr_d, rej_q, rej_d, err_q, err_d;
   logic                just_done_q, just_done_d;
   logic [9:0]          cnt_q, cnt_d;
   logic                beat_q, beat_d;
   logic [8:0]          beat_addr_q, beat_addr_d;
   logic [8:0]          hold_q;

   logic [31:0]         lba_arr [NUM_DEV];
   logic [7:0]          din_arr [NUM_DEV];
   logic [NUM_DEV-1:0]  req, gnt;
   logic [SLOT_W-1:0]   gnt_idx;

   for (genvar g = 0; g < NUM_DEV; g++) begin : g_unpack
      assign lba_arr[g] = bus.sd_lba[32*g +: 32];
      assign din_arr[g] = bus.sd_buff_din[8*g +: 8];
   end

   // The slot just served is masked for one IDLE cycle so a late request drop is not re-granted.
   assign req = (bus.sd_rd | bus.sd_wr) &
                ~(just_done_q ? (NUM_DEV'(1) << slot_q) : '0);

   rr_arbiter #(.N(NUM_DEV)) u_arb (
      .req_i (req),
      .ptr_i (ptr_q),
      .en_i  (state_q == IDLE),
      .gnt_o (gnt),
      .idx_o (gnt_idx)
   );

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         slot_q      <= '0;
         ptr_q       <= '0;
         lba_q       <= '0;
         wr_q        <= 1'b0;
         rej_q       <= 1'b0;
         err_q       <= 1'b0;
         just_done_q <= 1'b0;
         cnt_q       <= '0;
         beat_q      <= 1'b0;
         beat_addr_q <= '0;
         hold_q      <= '0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         ptr_q       <= ptr_d;
         lba_q       <= lba_d;
         wr_q        <= wr_d;
         rej_q       <= rej_d;
         err_q       <= err_d;
         just_done_q <= just_done_d;
         cnt_q       <= cnt_d;
         beat_q      <= beat_d;
         beat_addr_q <= beat_addr_d;
         hold_q      <= bus.sd_buff_addr;
      end
   end

   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      ptr_d       = ptr_q;
      lba_d       = lba_q;
      wr_d        = wr_q;
      rej_d       = rej_q;
      err_d       = 1'b0;
      just_done_d = 1'b0;
      cnt_d       = cnt_q;
      beat_d      = (state_q == XFER);
      beat_addr_d = cnt_q[8:0];
      unique case (state_q)
         IDLE: if (|gnt) begin
            slot_d  = gnt_idx;
            ptr_d   = (gnt_idx == SLOT_W'(NUM_DEV - 1)) ? '0 : gnt_idx + 1'b1;
            lba_d   = lba_arr[gnt_idx][SECT_W-1:0];
            wr_d    = bus.sd_wr[gnt_idx];
            rej_d   = !bus.dev_mounted[gnt_idx] || (lba_arr[gnt_idx][31:SECT_W] != '0);
            err_d   = rej_d || (bus.sd_rd[gnt_idx] && bus.sd_wr[gnt_idx]);
            state_d = ACK;
         end
         ACK: begin
            cnt_d   = '0;
            state_d = XFER;
         end
         XFER: begin
            cnt_d = cnt_q + 10'd1;
            if (cnt_d == 10'(SECTOR_BYTES)) state_d = DRAIN;
         end
         DRAIN: state_d = DONE;
         DONE: begin
            just_done_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.sd_ack       = '0;
      bus.sd_buff_addr = hold_q;
      bus.sd_buff_dout = '0;
      bus.sd_buff_wr   = 1'b0;
      bus.img_addr     = '0;
      bus.img_rd       = 1'b0;
      bus.img_wr       = 1'b0;
      bus.img_din      = '0;
      bus.err          = err_q;
      if (state_q == ACK || state_q == XFER || state_q == DRAIN)
         bus.sd_ack = NUM_DEV'(1) << slot_q;
      if (!wr_q) begin
         if (state_q == XFER) begin
            bus.img_addr = {slot_q, lba_q, cnt_q[8:0]};
            bus.img_rd   = !rej_q;
         end
         if (beat_q) begin
            bus.sd_buff_addr = beat_addr_q;
            bus.sd_buff_wr   = 1'b1;
            bus.sd_buff_dout = rej_q ? 8'h00 : bus.img_dout;
         end
      end else begin
         if (state_q == XFER) bus.sd_buff_addr = cnt_q[8:0];
         // Rejected writes still walk the buffer addresses but never touch the image.
         if (beat_q) begin
            bus.img_addr = {slot_q, lba_q, beat_addr_q};
            bus.img_din  = din_arr[slot_q];
            bus.img_wr   = !rej_q;
         end
      end
   end
endmodule

// File: tb/tb_sd_block_server.sv
// Bench for sd_block_server: vector table plus round-robin and reset-abort sequences.
module tb_sd_block_server;
   import sd_srv_pkg::*;

   typedef struct packed {
      logic [25:0] addr;
      logic [7:0]  data;
   } exp_t;

   typedef struct {
      int          slot;
      bit          rd;
      bit          wr;
      logic [31:0] lba;
      bit          mounted;
      int          exp_err;
      bit          rej;
      logic [7:0]  seed;
   } vec_t;

   logic clk_sys = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;
   int   err_total = 0;
   exp_t rq[$];
   exp_t wq[$];
   logic [7:0] mem [logic [25:0]];
   vec_t vecs [7];

   sd_block_server_if bus ();

   sd_block_server dut (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Image memory: one-cycle read latency, writes land in the same sparse store.
   always @(posedge clk_sys) begin
      if (bus.img_rd) bus.img_dout <= mem.exists(bus.img_addr) ? mem[bus.img_addr] : 8'hEE;
   end

   // Requester buffers: data valid one cycle after sd_buff_addr.
   always @(posedge clk_sys) begin
      for (int s = 0; s < 3; s++)
         bus.sd_buff_din[8*s +: 8] <= (8'd255 - bus.sd_buff_addr[7:0]) ^ (8'h11 * 8'(s));
   end

   always @(negedge clk_sys) begin
      exp_t e;
      if (reset_n) begin
         if (bus.sd_buff_wr) begin
            chk("rd_beat_expected", rq.size() > 0, 1);
            if (rq.size() > 0) begin
               e = rq.pop_front();
               chk("buff_addr", 32'(bus.sd_buff_addr), 32'(e.addr[8:0]));
               chk("buff_dout", 32'(bus.sd_buff_dout), 32'(e.data));
            end
         end
         if (bus.img_wr) begin
            chk("wr_beat_expected", wq.size() > 0, 1);
            if (wq.size() > 0) begin
               e = wq.pop_front();
               chk("img_addr", 32'(bus.img_addr), 32'(e.addr));
               chk("img_din", 32'(bus.img_din), 32'(e.data));
               mem[bus.img_addr] = bus.img_din;
            end
         end
         if (bus.err) err_total++;
      end
   end

   function automatic logic [25:0] iaddr(input int s, input logic [31:0] l, input int k);
      return {2'(s), l[14:0], 9'(k)};
   endfunction

   task automatic wait_ack_rise(output int n);
      n = 0;
      while (bus.sd_ack == '0 && n < 2000) begin @(negedge clk_sys); n++; end
   endtask

   task automatic measure_ack(output int n, output int first);
      n = 0;
      first = -1;
      while (bus.sd_ack != '0 && n < 2000) begin
         if (first < 0 && (bus.sd_buff_wr || bus.img_wr)) first = n;
         @(negedge clk_sys);
         n++;
      end
   endtask

   task automatic run_vec(input vec_t v);
      int s, n, first, e0;
      logic [7:0] d;
      s = v.slot;
      bus.dev_mounted    = 3'b111;
      bus.dev_mounted[s] = v.mounted;
      for (int k = 0; k < SECTOR_BYTES; k++) begin
         if (v.wr) begin
            d = 8'(255 - k) ^ (8'h11 * 8'(s));
            if (!v.rej) wq.push_back('{addr: iaddr(s, v.lba, k), data: d});
         end else begin
            d = 8'(k) ^ v.seed;
            if (!v.rej) mem[iaddr(s, v.lba, k)] = d;
            rq.push_back('{addr: 26'(k), data: v.rej ? 8'h00 : d});
         end
      end
      e0 = err_total;
      bus.sd_lba[32*s +: 32] = v.lba;
      bus.sd_rd[s] = v.rd;
      bus.sd_wr[s] = v.wr;
      wait_ack_rise(n);
      chk("grant_latency", n, 1);
      chk("ack_onehot", 32'(bus.sd_ack), 32'(3'b001 << s));
      bus.sd_rd[s] = 1'b0;
      bus.sd_wr[s] = 1'b0;
      measure_ack(n, first);
      chk("ack_width", n, 514);
      if (!(v.wr && v.rej)) chk("first_beat", first, 2);
      @(negedge clk_sys);
      chk("err_pulses", err_total - e0, v.exp_err);
      chk("rq_drained", rq.size(), 0);
      chk("wq_drained", wq.size(), 0);
      repeat (2) @(negedge clk_sys);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_ack"},      32'(bus.sd_ack), 0);
      chk({tag, "_buff_wr"},  32'(bus.sd_buff_wr), 0);
      chk({tag, "_buff_addr"},32'(bus.sd_buff_addr), 0);
      chk({tag, "_img_rd"},   32'(bus.img_rd), 0);
      chk({tag, "_img_wr"},   32'(bus.img_wr), 0);
      chk({tag, "_img_addr"}, 32'(bus.img_addr), 0);
      chk({tag, "_err"},      32'(bus.err), 0);
   endtask

   initial begin
      int n, first, e0;
      vecs[0] = '{SLOT_HDD, 1, 0, 32'd5,     1, 0, 0, 8'h5A};
      vecs[1] = '{SLOT_FD1, 0, 1, 32'd3,     1, 0, 0, 8'h00};
      vecs[2] = '{SLOT_FD2, 1, 0, 32'd7,     0, 1, 1, 8'h00};
      vecs[3] = '{SLOT_HDD, 1, 0, 32'd32768, 1, 1, 1, 8'h00};
      vecs[4] = '{SLOT_HDD, 1, 1, 32'd9,     1, 1, 0, 8'h00};
      vecs[5] = '{SLOT_FD1, 0, 1, 32'd4,     0, 1, 1, 8'h00};
      vecs[6] = '{SLOT_FD2, 1, 0, 32'd100,   1, 0, 0, 8'h33};

      reset_n         = 1'b0;
      bus.sd_lba      = '0;
      bus.sd_rd       = '0;
      bus.sd_wr       = '0;
      bus.dev_mounted = 3'b111;
      repeat (3) @(negedge clk_sys);
      check_idle_outputs("reset");
      reset_n = 1'b1;
      repeat (2) @(negedge clk_sys);

      // Round robin from pointer 0: all three slots read at once.
      e0 = err_total;
      for (int s = 0; s < 3; s++) begin
         bus.sd_lba[32*s +: 32] = 32'(s + 1);
         for (int k = 0; k < SECTOR_BYTES; k++) begin
            mem[iaddr(s, 32'(s + 1), k)] = 8'(k) ^ (8'h11 * 8'(s + 1));
            rq.push_back('{addr: 26'(k), data: 8'(k) ^ (8'h11 * 8'(s + 1))});
         end
      end
      bus.sd_rd = 3'b111;
      for (int o = 0; o < 3; o++) begin
         wait_ack_rise(n);
         chk(o == 0 ? "rr_grant_latency" : "rr_gap", n, o == 0 ? 1 : 2);
         chk("rr_order", 32'(bus.sd_ack), 32'(3'b001 << o));
         bus.sd_rd[o] = 1'b0;
         measure_ack(n, first);
         chk("rr_ack_width", n, 514);
      end
      repeat (3) @(negedge clk_sys);
      chk("rr_drained", rq.size(), 0);
      chk("rr_err", err_total - e0, 0);

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // Abort a write at beat 100 with the async reset.
      bus.dev_mounted = 3'b111;
      for (int k = 0; k < 100; k++)
         wq.push_back('{addr: iaddr(SLOT_HDD, 32'd11, k), data: 8'(255 - k) ^ 8'h11});
      bus.sd_lba[63:32] = 32'd11;
      bus.sd_wr[SLOT_HDD] = 1'b1;
      wait_ack_rise(n);
      chk("abort_grant", n, 1);
      bus.sd_wr[SLOT_HDD] = 1'b0;
      n = 0;
      while (wq.size() != 0 && n < 2000) begin @(negedge clk_sys); #1; n++; end
      chk("abort_reach_beat100", wq.size(), 0);
      @(posedge clk_sys);
      #1;
      chk("abort_img_wr_before", 32'(bus.img_wr), 1);
      reset_n = 1'b0;
      #1;
      chk("abort_ack_drop", 32'(bus.sd_ack), 0);
      chk("abort_img_wr_drop", 32'(bus.img_wr), 0);
      repeat (2) @(negedge clk_sys);
      check_idle_outputs("abort");
      reset_n = 1'b1;
      repeat (10) @(negedge clk_sys);
      chk("post_reset_no_ack", 32'(bus.sd_ack), 0);
      run_vec(vecs[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end
endmodule
